// File: rtl/shift_ser_pkg.sv
// Shared definitions for the shift-register serialiser controller:
// state encoding and datapath widths.
package shift_ser_pkg;

    localparam int BYTE_W = 8;
    localparam int GAP_W  = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_LOAD  = 2'd1;
    localparam state_t S_SHIFT = 2'd2;
    localparam state_t S_GAP   = 2'd3;

endpackage

// File: rtl/shift_ser_ctrl.sv
// Sequencer driving an external 8-bit right-shift register: accepts a byte,
// loads it, then clocks out NBITS bits LSB-first as a framed serial stream.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready for a byte; accept captures in_data into byte_q
// S_LOAD  | one cycle of sr_load with sr_data=byte_q; stall ignored
// S_SHIFT | one bit per non-stalled cycle, ena pulses the register
// S_GAP   | forced idle time between frames, gap_cnt counts down
module shift_ser_ctrl
    import shift_ser_pkg::*;
#(
    parameter int NBITS      = 8,
    parameter int GAP_CYCLES = 2
)(
    input  logic              clk,
    input  logic              areset,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    input  logic              stall,
    output logic              sr_load,
    output logic              sr_ena,
    output logic [BYTE_W-1:0] sr_data,
    input  logic              sr_q0,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(NBITS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(NBITS - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [BYTE_W-1:0] byte_q;
    logic              accept;
    logic              shift_fire;
    logic              last_fire;

    assign accept     = (state == S_IDLE) && in_valid;
    assign shift_fire = (state == S_SHIFT) && !stall;
    assign last_fire  = shift_fire && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                // A zero-length gap goes straight back to IDLE.
                if (last_fire) begin
                    state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state != S_IDLE);
        sr_load   = (state == S_LOAD);
        sr_data   = (state == S_LOAD) ? byte_q : '0;
        sr_ena    = shift_fire;
        ser_valid = shift_fire;
        ser_out   = shift_fire & sr_q0;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            byte_q <= '0;
        end else if (accept) begin
            byte_q <= in_data;
        end
    end

    // bit_cnt reaches NBITS on the final bit and stays there until the next LOAD.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            bit_cnt <= '0;
        end else if (state == S_LOAD) begin
            bit_cnt <= '0;
        end else if (shift_fire) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            gap_cnt <= '0;
        end else if (last_fire) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == S_GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_fire;
        end
    end

endmodule
